// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed wait
// latency. It accepts one aligned read or write while idle and stalls the
// pipeline until the response. After LATENCY wait cycles it either returns
// read data (rd_valid) or commits the store (wr_done).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   dm_rd_en, dm_wr_en   read / write request (held while stall is high)
//   addr, wr_data        byte address (word index addr[AW:1]), store data
//   stall                combinational; high while a request is outstanding
//   rd_data              last read result, held until the next read completes
//   rd_valid, wr_done    one-cycle completion pulses in the response cycle
//   err                  one-cycle pulse per cycle a bad request is presented
//   busy                 high while an access is in flight (WAIT or RESP)
module dmem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned AW      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dm_rd_en,
  input  logic          dm_wr_en,
  input  logic [15:0]   addr,
  input  logic [15:0]   wr_data,
  output logic          stall,
  output logic [15:0]   rd_data,
  output logic          rd_valid,
  output logic          wr_done,
  output logic          err,
  output logic          busy
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            op_wr;
  logic [AW-1:0]   idx_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            req;
  logic            bad;
  logic            accept;
  logic            unused_addr;

  // Upper address bits are intentionally ignored; the word index wraps.
  assign unused_addr = &{1'b0, addr[15:AW+1]};

  // Request classification; accept/err are gated by rst_n so every output
  // reads zero while reset is held, even with a request on the inputs.
  assign req    = dm_rd_en | dm_wr_en;
  assign bad    = (dm_rd_en & dm_wr_en) | (req & addr[0]);
  assign accept = rst_n & (state == IDLE) & req & ~bad;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = WAIT;
      WAIT: if (cnt == CW'(1)) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; completion pulses come straight from the RESP state.
  always_comb begin
    stall    = 1'b0;
    err      = 1'b0;
    busy     = 1'b0;
    rd_valid = 1'b0;
    wr_done  = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        err   = rst_n & bad;
      end
      WAIT: begin
        stall = 1'b1;
        busy  = 1'b1;
      end
      RESP: begin
        busy     = 1'b1;
        rd_valid = ~op_wr;
        wr_done  = op_wr;
      end
      default: ;
    endcase
  end

  // Request latch, wait counter and read-data register. Read data is loaded
  // on the edge entering RESP so it is already valid during the rd_valid cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_wr   <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= CW'(LATENCY);
            op_wr  <= dm_wr_en;
            idx_q  <= addr[AW:1];
            data_q <= wr_data;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if ((cnt == CW'(1)) && !op_wr) begin
            rd_data <= mem[idx_q];
          end
        end
        RESP: begin
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Storage array, not reset. A reset during WAIT/RESP forces IDLE
  // asynchronously, so an aborted write never reaches this port.
  always_ff @(posedge clk) begin
    if ((state == RESP) && op_wr) begin
      mem[idx_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random stimulus for dmem_responder, checked
// each cycle against a transaction-level model (outstanding access + age).
module tb_dmem_responder;

  localparam int unsigned LAT = 4;
  localparam int unsigned AWB = 8;

  logic        clk;
  logic        rst_n;
  logic        dm_rd_en;
  logic        dm_wr_en;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic        stall;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        wr_done;
  logic        err;
  logic        busy;

  dmem_responder #(.LATENCY(LAT), .AW(AWB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dm_rd_en (dm_rd_en),
    .dm_wr_en (dm_wr_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .stall    (stall),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_done  (wr_done),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory image plus one outstanding transaction by age.
  logic [15:0] m_mem   [256];
  bit          m_known [256];
  bit          m_out;
  int          m_age;
  bit          m_wr;
  logic [7:0]  m_idx;
  logic [15:0] m_data;
  logic [15:0] m_last;
  bit          m_last_known;
  int          stall_seen;
  int          done_seen;
  int          valid_seen;
  int          err_seen;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out        = 1'b0;
    m_age        = 0;
    m_last       = 16'h0000;
    m_last_known = 1'b1;
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic step(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    logic e_stall, e_err, e_busy, e_valid, e_done, rq, bd, resp;
    logic [7:0] ia;
    dm_rd_en = rd;
    dm_wr_en = wr;
    addr     = a;
    wr_data  = d;
    rq = rd | wr;
    bd = (rd & wr) | (rq & a[0]);
    ia = 8'((a >> 1) & 16'h00FF);
    @(negedge clk);
    if (!m_out) begin
      e_stall = rq & ~bd;
      e_err   = bd;
      e_busy  = 1'b0;
      e_valid = 1'b0;
      e_done  = 1'b0;
    end else begin
      resp    = (m_age == int'(LAT) + 1);
      e_stall = (m_age <= int'(LAT));
      e_err   = 1'b0;
      e_busy  = 1'b1;
      e_valid = resp & ~m_wr;
      e_done  = resp & m_wr;
      if (e_valid) begin
        m_last       = m_mem[m_idx];
        m_last_known = m_known[m_idx];
      end
    end
    chk("stall",    16'(stall),    16'(e_stall));
    chk("err",      16'(err),      16'(e_err));
    chk("busy",     16'(busy),     16'(e_busy));
    chk("rd_valid", 16'(rd_valid), 16'(e_valid));
    chk("wr_done",  16'(wr_done),  16'(e_done));
    if (m_last_known) chk("rd_data", rd_data, m_last);
    if (stall)    stall_seen++;
    if (wr_done)  done_seen++;
    if (rd_valid) valid_seen++;
    if (err)      err_seen++;
    @(posedge clk);
    if (!m_out) begin
      if (rq && !bd) begin
        m_out  = 1'b1;
        m_age  = 1;
        m_wr   = wr;
        m_idx  = ia;
        m_data = d;
      end
    end else if (m_age == int'(LAT) + 1) begin
      if (m_wr) begin
        m_mem[m_idx]   = m_data;
        m_known[m_idx] = 1'b1;
      end
      m_out = 1'b0;
    end else begin
      m_age++;
    end
    #1;
  endtask

  // Full access: hold the request through the stall, then drop it in RESP.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    for (int i = 0; i < int'(LAT) + 1; i++) step(rd, wr, a, d);
    step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic clear_seen();
    stall_seen = 0;
    done_seen  = 0;
    valid_seen = 0;
    err_seen   = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    model_reset();
    clear_seen();

    // Reset with a request presented: every output must read zero.
    rst_n    = 1'b0;
    dm_rd_en = 1'b1;
    dm_wr_en = 1'b0;
    addr     = 16'h0010;
    wr_data  = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall",    16'(stall),    16'h0);
    chk("rst_err",      16'(err),      16'h0);
    chk("rst_busy",     16'(busy),     16'h0);
    chk("rst_rd_valid", 16'(rd_valid), 16'h0);
    chk("rst_wr_done",  16'(wr_done),  16'h0);
    chk("rst_rd_data",  rd_data,       16'h0000);
    dm_rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write 0xBEEF to 0x0010: five stall cycles, one wr_done.
    clear_seen();
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("wr_stall_len", 16'(stall_seen), 16'(LAT + 1));
    chk("wr_done_cnt",  16'(done_seen),  16'd1);

    // Read it back.
    clear_seen();
    access(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("rd_stall_len", 16'(stall_seen), 16'(LAT + 1));
    chk("rd_valid_cnt", 16'(valid_seen), 16'd1);
    chk("rd_hold",      rd_data,         16'hBEEF);

    // Read held through RESP plus one cycle: second access starts after RESP.
    clear_seen();
    for (int i = 0; i < int'(LAT) + 3; i++) step(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("held_valid_cnt", 16'(valid_seen), 16'd1);
    for (int i = 0; i < int'(LAT) + 1; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("held_valid_cnt2", 16'(valid_seen), 16'd2);

    // Rejected requests: misaligned, then both enables.
    clear_seen();
    step(1'b0, 1'b1, 16'h0011, 16'h0BAD);
    step(1'b0, 1'b1, 16'h0011, 16'h0BAD);
    step(1'b1, 1'b1, 16'h0010, 16'h0BAD);
    step(1'b1, 1'b1, 16'h0010, 16'h0BAD);
    chk("err_cnt",     16'(err_seen),   16'd4);
    chk("err_nostall", 16'(stall_seen), 16'd0);
    access(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("after_err_rd", rd_data, 16'hBEEF);

    // Reset in the third WAIT cycle aborts a write.
    access(1'b0, 1'b1, 16'h0020, 16'h1111);
    step(1'b0, 1'b1, 16'h0020, 16'h1234);
    step(1'b0, 1'b1, 16'h0020, 16'h1234);
    step(1'b0, 1'b1, 16'h0020, 16'h1234);
    rst_n = 1'b0;
    #1;
    chk("abort_stall",    16'(stall),    16'h0);
    chk("abort_busy",     16'(busy),     16'h0);
    chk("abort_wr_done",  16'(wr_done),  16'h0);
    chk("abort_rd_valid", 16'(rd_valid), 16'h0);
    chk("abort_err",      16'(err),      16'h0);
    chk("abort_rd_data",  rd_data,       16'h0000);
    model_reset();
    dm_wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_seen();
    for (int i = 0; i < int'(LAT) + 2; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("abort_no_done", 16'(done_seen), 16'd0);
    access(1'b1, 1'b0, 16'h0020, 16'h0000);
    chk("abort_rd", rd_data, 16'h1111);

    // Index wrap: 0x0202 and 0x0002 share word 1.
    access(1'b0, 1'b1, 16'h0202, 16'h5A5A);
    access(1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("wrap_rd", rd_data, 16'h5A5A);

    // Random traffic over a small word window with random upper bits.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra;
      logic        rr, rw;
      ra       = 16'($urandom_range(0, 65535));
      ra[8:1]  = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 7) != 0) ra[0] = 1'b0;
      rr = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        rr = 1'b0;
        rw = 1'b0;
      end
      step(rr, rw, ra, 16'($urandom_range(0, 65535)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
